// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default operand width.
package mult_div_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_DIV   = 2'b01,
    MDU_MULTU = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The dividend is shifted out of the quotient register into the partial
// remainder one bit per step; the new quotient bit is shifted in at the LSB.
module mdu_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo,
  output logic             o_negative
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // Trial subtract; restore the shifted remainder when it goes negative
  always_comb begin
    w_shifted  = {i_rem, i_quo[WIDTH-1]};
    w_trial    = w_shifted - {1'b0, i_divisor};
    o_negative = w_trial[WIDTH];
    if (o_negative) begin
      o_rem = w_shifted[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Signed multiply is radix-2 Booth; divide is restoring on magnitudes with a
// final sign fix. Latency is WIDTH+1 edges from an accepted start.
// Optional feature macro: MDU_UNSIGNED_EN enables MULTU/DIVU on op 10/11;
// without it op[1] is ignored and both ops run signed.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter  int WIDTH = MDU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       r_state;
  mdu_state_e       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   r_mcand;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic             r_qPrev;
  logic             r_isDiv;
  logic             r_divByZero;
  logic             r_aSign;
  logic             r_bSign;
  logic             r_multFix;
  logic             r_done;
  logic             r_divZero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  mdu_op_e            w_op;
  logic               w_isDiv;
  logic               w_isSigned;
  logic               w_bZero;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH:0]     w_boothSum;
  logic [WIDTH-1:0]   w_divRem;
  logic [WIDTH-1:0]   w_divQuo;
  logic               w_unusedTrialSign;
  logic [2*WIDTH-1:0] w_multCorr;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  assign done     = r_done;
  assign div_zero = r_divZero;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Decode the requested op and form operand magnitudes for division
  always_comb begin
    w_op       = mdu_op_e'(op);
    w_isDiv    = 1'b0;
    w_isSigned = 1'b1;
    case (w_op)
      MDU_DIV, MDU_DIVU: w_isDiv = 1'b1;
      default:           w_isDiv = 1'b0;
    endcase
`ifdef MDU_UNSIGNED_EN
    w_isSigned = (w_op == MDU_MULT) || (w_op == MDU_DIV);
`endif
    w_bZero = (b == '0);
    w_aMag  = (w_isSigned && a[WIDTH-1]) ? -a : a;
    w_bMag  = (w_isSigned && b[WIDTH-1]) ? -b : b;
  end

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    case ({r_q[0], r_qPrev})
      2'b01:   w_boothSum = r_acc + r_mcand;
      2'b10:   w_boothSum = r_acc - r_mcand;
      default: w_boothSum = r_acc;
    endcase
  end

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_divStep (
    .i_rem     (r_acc[WIDTH-1:0]),
    .i_quo     (r_q),
    .i_divisor (r_divisor),
    .o_rem     (w_divRem),
    .o_quo     (w_divQuo),
    .o_negative(w_unusedTrialSign)
  );

  // Final results: Booth reads the multiplier as signed, so an unsigned
  // multiplier with its top bit set needs a*2^WIDTH added back
  always_comb begin
    w_multCorr = r_multFix ? {r_mcand[WIDTH-1:0], {WIDTH{1'b0}}} : '0;
    w_product  = {r_acc[WIDTH-1:0], r_q} + w_multCorr;
    w_quoFix   = (r_aSign ^ r_bSign) ? -r_q : r_q;
    w_remFix   = r_aSign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next state and busy; divide by zero jumps straight to FIX
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_nextState = (w_isDiv && w_bZero) ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_count == CNT_W'(1)) w_nextState = ST_FIX;
      end
      ST_FIX: begin
        busy        = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate one step per RUN edge, commit in FIX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_qPrev     <= 1'b0;
      r_isDiv     <= 1'b0;
      r_divByZero <= 1'b0;
      r_aSign     <= 1'b0;
      r_bSign     <= 1'b0;
      r_multFix   <= 1'b0;
      r_done      <= 1'b0;
      r_divZero   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count     <= CNT_W'(WIDTH);
            r_acc       <= '0;
            r_qPrev     <= 1'b0;
            r_q         <= w_isDiv ? w_aMag : b;
            r_mcand     <= w_isSigned ? {a[WIDTH-1], a} : {1'b0, a};
            r_divisor   <= w_bMag;
            r_isDiv     <= w_isDiv;
            r_divByZero <= w_isDiv && w_bZero;
            r_aSign     <= w_isSigned && a[WIDTH-1];
            r_bSign     <= w_isSigned && b[WIDTH-1];
            r_multFix   <= !w_isSigned && b[WIDTH-1];
            r_divZero   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_count <= r_count - 1'b1;
          if (r_isDiv) begin
            r_acc <= {1'b0, w_divRem};
            r_q   <= w_divQuo;
          end else begin
            r_acc   <= {w_boothSum[WIDTH], w_boothSum[WIDTH:1]};
            r_q     <= {w_boothSum[0], r_q[WIDTH-1:1]};
            r_qPrev <= r_q[0];
          end
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (r_divByZero) begin
            r_divZero <= 1'b1;
          end else if (r_isDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
          end else begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32). Expected values are worked by
// hand; op 10/11 expectations depend on MDU_UNSIGNED_EN.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int testsRun    = 0;
  int testsFailed = 0;

  mult_div_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(divZero),
    .hi      (hi),
    .lo      (lo)
  );

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  // Present a request; called away from the rising edge, returns just after E0
  task automatic kickOff(input logic [1:0] opV, input logic [31:0] aV, input logic [31:0] bV);
    start = 1'b1;
    op    = opV;
    a     = aV;
    b     = bV;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; edges is the edge index after E0, -1 on timeout
  task automatic waitDone(output int edges, output int busyEdges, output logic busyAtDone);
    edges      = -1;
    busyEdges  = 0;
    busyAtDone = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (done) begin
        edges      = k;
        busyAtDone = busy;
        break;
      end
      if (busy) busyEdges++;
      @(posedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clock);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    testsRun++; if (divZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_divzero: got %b expected 0", divZero); end
    testsRun++; if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
    testsRun++; if (lo !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int e, be;
    logic bd;
    @(negedge clock);
    kickOff(2'b00, 32'hFFFFFFFD, 32'd7);
    waitDone(e, be, bd);
    testsRun++; if (e !== 33) begin testsFailed++; $display("[TB] FAIL mult_latency: got %0d expected 33", e); end
    testsRun++; if (be !== 33) begin testsFailed++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 33", be); end
    testsRun++; if (bd !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult_busy_at_done: got %b expected 0", bd); end
    testsRun++; if (hi !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
    testsRun++; if (lo !== 32'hFFFFFFEB) begin testsFailed++; $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo); end
    @(negedge clock);
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_div();
    int e, be;
    logic bd;
    @(negedge clock);
    kickOff(2'b01, 32'hFFFFFFF9, 32'd2);
    waitDone(e, be, bd);
    testsRun++; if (e !== 33) begin testsFailed++; $display("[TB] FAIL div_latency: got %0d expected 33", e); end
    testsRun++; if (lo !== 32'hFFFFFFFD) begin testsFailed++; $display("[TB] FAIL div_lo: got %h expected fffffffd", lo); end
    testsRun++; if (hi !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL div_hi: got %h expected ffffffff", hi); end
    testsRun++; if (divZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL div_divzero: got %b expected 0", divZero); end
  endtask

  task automatic test_div_zero();
    int e, be;
    logic bd;
    @(negedge clock);
    kickOff(2'b01, 32'd5, 32'd0);
    waitDone(e, be, bd);
    testsRun++; if (e !== 1) begin testsFailed++; $display("[TB] FAIL dz_latency: got %0d expected 1", e); end
    testsRun++; if (divZero !== 1'b1) begin testsFailed++; $display("[TB] FAIL dz_flag: got %b expected 1", divZero); end
    testsRun++; if (hi !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL dz_hi_held: got %h expected ffffffff", hi); end
    testsRun++; if (lo !== 32'hFFFFFFFD) begin testsFailed++; $display("[TB] FAIL dz_lo_held: got %h expected fffffffd", lo); end
    repeat (3) @(negedge clock);
    testsRun++; if (divZero !== 1'b1) begin testsFailed++; $display("[TB] FAIL dz_flag_hold: got %b expected 1", divZero); end
    kickOff(2'b00, 32'd6, 32'd7);
    testsRun++; if (divZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL dz_clear_on_start: got %b expected 0", divZero); end
    waitDone(e, be, bd);
    testsRun++; if (lo !== 32'd42) begin testsFailed++; $display("[TB] FAIL dz_next_mult_lo: got %h expected 0000002a", lo); end
    testsRun++; if (hi !== 32'd0) begin testsFailed++; $display("[TB] FAIL dz_next_mult_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_overflow();
    int e, be;
    logic bd;
    @(negedge clock);
    kickOff(2'b01, 32'h80000000, 32'hFFFFFFFF);
    waitDone(e, be, bd);
    testsRun++; if (lo !== 32'h80000000) begin testsFailed++; $display("[TB] FAIL ovf_lo: got %h expected 80000000", lo); end
    testsRun++; if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL ovf_hi: got %h expected 00000000", hi); end
    testsRun++; if (divZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_divzero: got %b expected 0", divZero); end
  endtask

  task automatic test_ignored_start();
    int doneCount = 0;
    int firstAt   = -1;
    @(negedge clock);
    kickOff(2'b00, 32'd5, 32'd5);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 5; k < 45; k++) begin
      @(negedge clock);
      if (done) begin
        doneCount++;
        if (firstAt < 0) firstAt = k;
      end
      @(posedge clock);
    end
    testsRun++; if (doneCount !== 1) begin testsFailed++; $display("[TB] FAIL ign_done_count: got %0d expected 1", doneCount); end
    testsRun++; if (firstAt !== 33) begin testsFailed++; $display("[TB] FAIL ign_done_edge: got %0d expected 33", firstAt); end
    testsRun++; if (lo !== 32'd25) begin testsFailed++; $display("[TB] FAIL ign_lo: got %h expected 00000019", lo); end
    testsRun++; if (hi !== 32'd0) begin testsFailed++; $display("[TB] FAIL ign_hi: got %h expected 00000000", hi); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ign_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int e, be;
    logic bd;
    @(negedge clock);
    kickOff(2'b00, 32'hFFFFFFFD, 32'd7);
    waitDone(e, be, bd);
    testsRun++; if (lo !== 32'hFFFFFFEB) begin testsFailed++; $display("[TB] FAIL b2b_first_lo: got %h expected ffffffeb", lo); end
    kickOff(2'b01, 32'd100, 32'hFFFFFFF9);
    waitDone(e, be, bd);
    testsRun++; if (e !== 33) begin testsFailed++; $display("[TB] FAIL b2b_latency: got %0d expected 33", e); end
    testsRun++; if (lo !== 32'hFFFFFFF2) begin testsFailed++; $display("[TB] FAIL b2b_lo: got %h expected fffffff2", lo); end
    testsRun++; if (hi !== 32'd2) begin testsFailed++; $display("[TB] FAIL b2b_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    kickOff(2'b00, 32'd1234, 32'd5678);
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    testsRun++; if (divZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_divzero: got %b expected 0", divZero); end
    testsRun++; if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL midrst_hi: got %h expected 00000000", hi); end
    testsRun++; if (lo !== 32'h0) begin testsFailed++; $display("[TB] FAIL midrst_lo: got %h expected 00000000", lo); end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    testsRun++; if ({busy, done} !== 2'b00) begin testsFailed++; $display("[TB] FAIL midrst_idle_after: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_op10();
    int e, be;
    logic bd;
    logic [31:0] expHi, expLo;
    @(negedge clock);
    kickOff(2'b10, 32'hFFFFFFFF, 32'd2);
    waitDone(e, be, bd);
`ifdef MDU_UNSIGNED_EN
    expHi = 32'h00000001;
`else
    expHi = 32'hFFFFFFFF;
`endif
    testsRun++; if (e !== 33) begin testsFailed++; $display("[TB] FAIL op10_latency: got %0d expected 33", e); end
    testsRun++; if (hi !== expHi) begin testsFailed++; $display("[TB] FAIL op10_hi: got %h expected %h", hi, expHi); end
    testsRun++; if (lo !== 32'hFFFFFFFE) begin testsFailed++; $display("[TB] FAIL op10_lo: got %h expected fffffffe", lo); end
    @(negedge clock);
    kickOff(2'b10, 32'd3, 32'h80000000);
    waitDone(e, be, bd);
`ifdef MDU_UNSIGNED_EN
    expHi = 32'h00000001;
`else
    expHi = 32'hFFFFFFFE;
`endif
    testsRun++; if (hi !== expHi) begin testsFailed++; $display("[TB] FAIL op10_topbit_hi: got %h expected %h", hi, expHi); end
    testsRun++; if (lo !== 32'h80000000) begin testsFailed++; $display("[TB] FAIL op10_topbit_lo: got %h expected 80000000", lo); end
    @(negedge clock);
    kickOff(2'b11, 32'hFFFFFFFF, 32'd2);
    waitDone(e, be, bd);
`ifdef MDU_UNSIGNED_EN
    expHi = 32'h00000001;
    expLo = 32'h7FFFFFFF;
`else
    expHi = 32'hFFFFFFFF;
    expLo = 32'h00000000;
`endif
    testsRun++; if (hi !== expHi) begin testsFailed++; $display("[TB] FAIL op11_hi: got %h expected %h", hi, expHi); end
    testsRun++; if (lo !== expLo) begin testsFailed++; $display("[TB] FAIL op11_lo: got %h expected %h", lo, expLo); end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    test_op10();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
